// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Seven-segment pattern and code constants shared by the
//                display encoder and the display-snooping decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment patterns, bit0 = a ... bit6 = g, 1 = lit
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-numeric codes
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    // Decoded digit: code plus illegal-pattern flag
    typedef struct packed {
        logic [3:0] code;
        logic       err;
    } seg7_dec_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder_if
//  Description : Display bus (segments + digit select) and reconstructed
//                frame outputs of the seven-segment snooper.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;

    // Display driver side: drives the bus, observes the decoded frame
    modport master (
        output seg, dig_sel,
        input  digits, digit_err, frame_valid
    );

    // Decoder side: snoops the bus, publishes the decoded frame
    modport slave (
        input  seg, dig_sel,
        output digits, digit_err, frame_valid
    );

endinterface : seg7_decoder_if
`default_nettype wire

// File: rtl/seg7_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_lookup
//  Description : Combinational seven-segment pattern to 4-bit code decode,
//                flagging any pattern that is not a known glyph.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_lookup
    import seg7_pkg::*;
(
    input  wire logic [6:0] seg_i,
    output logic      [3:0] code_o,
    output logic            err_o
);

    // Pattern to code map; unknown patterns decode to CODE_BAD with err set
    always_comb begin
        code_o = CODE_BAD;
        err_o  = 1'b0;
        case (seg_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_E:     code_o = CODE_E;
            SEG_BLANK: code_o = CODE_BLANK;
            default: begin
                code_o = CODE_BAD;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule : seg7_lookup
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Snoops a multiplexed seven-segment bus, accepts each digit
//                after it has been stable for STABLE_CYCLES samples and
//                publishes a frame once every digit has been captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    seg7_decoder_if.slave bus
);

    localparam int                 RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W:0]     RUN_CMP = (RUN_W + 1)'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   s_sel_q;
    logic [6:0]              s_seg_q;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [RUN_W:0]          run_inc;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    seg7_dec_t               shadow_q [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    fv_q;

    logic                    w_onehot;
    logic                    w_same;
    logic                    w_capture;
    logic                    w_publish;
    seg7_dec_t               w_dec;

    seg7_lookup u_lookup (
        .seg_i  (bus.seg),
        .code_o (w_dec.code),
        .err_o  (w_dec.err)
    );

    assign w_onehot  = $onehot(bus.dig_sel);
    assign w_same    = (bus.dig_sel == s_sel_q) && (bus.seg == s_seg_q);
    assign run_inc   = {1'b0, run_q} + 1'b1;
    assign w_publish = &mask_q;

    // Run counter next state and the single capture strobe per stable interval.
    // A held value keeps rewriting RUN_MAX, so a capture is only taken when the
    // counter was not already saturated on the same sample.
    always_comb begin
        run_d     = '0;
        w_capture = 1'b0;
        if (!w_onehot) begin
            run_d = '0;
        end else if (w_same && (run_q != '0)) begin
            run_d = (run_inc > RUN_CMP) ? RUN_MAX : run_inc[RUN_W-1:0];
        end else begin
            run_d = RUN_W'(1);
        end
        w_capture = w_onehot && (run_d == RUN_MAX) && !(w_same && (run_q == RUN_MAX));
    end

    // Capture mask: a publish clears it, keeping only a digit captured on that edge
    always_comb begin
        mask_d = mask_q | (w_capture ? bus.dig_sel : '0);
        if (w_publish) begin
            mask_d = w_capture ? bus.dig_sel : '0;
        end
    end

    // Sample registers, run counter, mask and published outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_sel_q  <= '0;
            s_seg_q  <= '0;
            run_q    <= '0;
            mask_q   <= '0;
            digits_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
        end else begin
            s_sel_q <= bus.dig_sel;
            s_seg_q <= bus.seg;
            run_q   <= run_d;
            mask_q  <= mask_d;
            fv_q    <= w_publish;
            if (w_publish) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits_q[4*i +: 4] <= shadow_q[i].code;
                    err_q[i]           <= shadow_q[i].err;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
            // Shadow slot: overwritten by every capture of this digit
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_q[g] <= '0;
                end else if (w_capture && bus.dig_sel[g]) begin
                    shadow_q[g] <= w_dec;
                end
            end
        end
    endgenerate

    assign bus.digits      = digits_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = fv_q;

endmodule : seg7_decoder
`default_nettype wire
